seg_scan_display: RTL

- Downstream consumer of the team's BCD counter chain, including the 3-bit mod-6 counter digit, zero-extended to 4 bits.
- Captures a packed vector of BCD digits and drives a time-multiplexed common-anode 7-segment display.
- Contains a scan prescaler, a rotating digit select, a frame-synchronised tear-free load, optional leading-zero blanking and per-digit segment decode.

---
 rtl/seg_scan_display.sv | 117 +++++++++++
 1 files changed

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed common-anode 7-segment driver.
// Ports: sysClk/sysRst(async, low); load/digitsIn tear-free BCD capture;
//   blankLeadingZero; anode (one-hot low), seg {g..a} low, frameDone pulse.
module seg_scan_display #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic                  sysClk,
  input  logic                  sysRst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digitsIn,
  input  logic                  blankLeadingZero,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            seg,
  output logic                  frameDone
);

  localparam int IW = $clog2(DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [PW-1:0] LAST_PRE = PW'(SCAN_DIV - 1);
  localparam logic [DIGITS-1:0] ONE = DIGITS'(1);

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_scan_idx;
  logic [4*DIGITS-1:0]   r_shadow;
  logic [4*DIGITS-1:0]   r_snap;
  logic                  r_pending;

  logic                  w_presc_tc;
  logic                  w_wrap;
  logic [3:0]            w_digit;
  logic [DIGITS-1:0]     w_blank_mask;
  logic                  w_zero_run;
  logic                  w_blank;
  logic [6:0]            w_code;
  logic [DIGITS-1:0]     w_onehot;

  assign w_presc_tc = (r_presc == LAST_PRE);
  assign w_wrap     = w_presc_tc & (r_scan_idx == LAST_IDX);
  assign w_digit    = r_snap[{r_scan_idx, 2'b00} +: 4];
  assign w_onehot   = ONE << r_scan_idx;

  always_ff @(posedge sysClk or negedge sysRst) begin
    if (!sysRst) begin
      r_presc    <= '0;
      r_scan_idx <= '0;
    end else if (w_presc_tc) begin
      r_presc    <= '0;
      r_scan_idx <= (r_scan_idx == LAST_IDX) ? '0 : r_scan_idx + 1'b1;
    end else begin
      r_presc    <= r_presc + 1'b1;
    end
  end

  // Snapshot only moves on the wrap edge; a load on that very edge
  // bypasses the shadow since it is the newer request.
  always_ff @(posedge sysClk or negedge sysRst) begin
    if (!sysRst) begin
      r_shadow  <= '0;
      r_snap    <= '0;
      r_pending <= 1'b0;
    end else if (w_wrap) begin
      r_pending <= 1'b0;
      if (load)
        r_snap <= digitsIn;
      else if (r_pending)
        r_snap <= r_shadow;
    end else if (load) begin
      r_shadow  <= digitsIn;
      r_pending <= 1'b1;
    end
  end

  // Walk from the top digit down; the zero run ends at the first
  // nonzero code (dashes included). Digit 0 always shows.
  always_comb begin
    w_zero_run   = 1'b1;
    w_blank_mask = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_zero_run      = w_zero_run & (r_snap[4*k +: 4] == 4'd0);
      w_blank_mask[k] = w_zero_run & (k != 0);
    end
  end

  assign w_blank = blankLeadingZero & w_blank_mask[r_scan_idx];

  always_comb begin
    w_code = 7'b0111111;
    unique case (w_digit)
      4'd0:    w_code = 7'b1000000;
      4'd1:    w_code = 7'b1111001;
      4'd2:    w_code = 7'b0100100;
      4'd3:    w_code = 7'b0110000;
      4'd4:    w_code = 7'b0011001;
      4'd5:    w_code = 7'b0010010;
      4'd6:    w_code = 7'b0000010;
      4'd7:    w_code = 7'b1111000;
      4'd8:    w_code = 7'b0000000;
      4'd9:    w_code = 7'b0010000;
      default: w_code = 7'b0111111;
    endcase
  end

  always_ff @(posedge sysClk or negedge sysRst) begin
    if (!sysRst) begin
      anode     <= '1;
      seg       <= 7'b1111111;
      frameDone <= 1'b0;
    end else begin
      anode     <= ~w_onehot;
      seg       <= w_blank ? 7'b1111111 : w_code;
      frameDone <= w_wrap;
    end
  end

endmodule
